// File: rtl/cfg_scan_store.sv
// rtl/cfg_scan_store.sv - double-buffered scan-loaded configuration store with dual registered read ports
// Optional CRC-16 qualification of each load is enabled by defining CFG_SCAN_CRC_EN.
module cfg_scan_store #(
    parameter int MEM_LEN  = 128,
    parameter int DATA_W   = 8,
    parameter int HDR_BITS = 64,
    parameter int ADDR_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_in,
    input  logic                scan_en,
    output logic                scan_out,
    input  logic                apply_ok,
    input  logic [ADDR_W-1:0]   addr,
    output logic [HDR_BITS-1:0] hdr_out,
    output logic [DATA_W-1:0]   d_out_0,
    output logic [DATA_W-1:0]   d_out_1,
    output logic                cfg_valid,
    output logic                cfg_pending,
    output logic                cfg_err
);

`ifdef CFG_SCAN_CRC_EN
    localparam int CRC_W = 16;
`else
    localparam int CRC_W = 0;
`endif
    localparam int MEM_BITS = MEM_LEN * DATA_W;
    localparam int L        = CRC_W + HDR_BITS + MEM_BITS;
    localparam int CNT_W    = $clog2(L + 2);
    localparam int IDX_W    = $clog2(MEM_LEN);
    localparam int HDR_OFF  = CRC_W;
    localparam int MEM_OFF  = CRC_W + HDR_BITS;

    localparam logic [CNT_W-1:0]  CNT_L    = CNT_W'(L);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(L + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   MEM_LEN_X = (ADDR_W + 1)'(MEM_LEN);

    // Bit 0 is the chain head; bit L-1 is the MSB of the last memory word.
    logic [L-1:0]       shadow;
    logic [DATA_W-1:0]  act_mem [MEM_LEN];
    logic [CNT_W-1:0]   bit_cnt;
    logic               scan_en_q;

    logic scan_rise;
    logic scan_fall;
    logic commit;
    logic crc_ok;
    logic load_ok;

    assign scan_rise = scan_en & ~scan_en_q;
    assign scan_fall = ~scan_en & scan_en_q;
    assign commit    = cfg_pending & apply_ok;
    assign load_ok   = (bit_cnt == CNT_L) && crc_ok;
    assign scan_out  = shadow[L-1];

`ifdef CFG_SCAN_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_base;
    logic [15:0] crc_next;

    // Serial CCITT step, restarting from 0xFFFF on the first bit of a burst.
    always_comb begin
        crc_base = scan_rise ? 16'hFFFF : crc_q;
        crc_next = {crc_base[14:0], 1'b0} ^ ((crc_base[15] ^ scan_in) ? 16'h1021 : 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= 16'h0000;
        end else if (scan_en) begin
            crc_q <= crc_next;
        end
    end

    assign crc_ok = (crc_q == 16'h0000);
`else
    assign crc_ok = 1'b1;
`endif

    // Read-port address decode; port 1 wraps exactly at MEM_LEN, beyond that reads zero.
    logic [ADDR_W:0]  addr_x;
    logic [ADDR_W:0]  addr_p1;
    logic             rd0_ok;
    logic             rd1_ok;
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;

    always_comb begin
        addr_x  = {1'b0, addr};
        addr_p1 = addr_x + (ADDR_W + 1)'(1);
        rd0_ok  = addr_x < MEM_LEN_X;
        rd1_ok  = addr_p1 <= MEM_LEN_X;
        idx0    = addr[IDX_W-1:0];
        idx1    = (addr_p1 == MEM_LEN_X) ? '0 : addr_p1[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            bit_cnt     <= '0;
            scan_en_q   <= 1'b0;
            hdr_out     <= '0;
            d_out_0     <= '0;
            d_out_1     <= '0;
            cfg_valid   <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            for (int i = 0; i < MEM_LEN; i++) begin
                act_mem[i] <= '0;
            end
        end else begin
            scan_en_q <= scan_en;

            if (scan_en) begin
                shadow <= {shadow[L-2:0], scan_in};
                if (scan_rise) begin
                    bit_cnt <= CNT_ONE;
                end else if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + CNT_ONE;
                end
            end

            if (scan_fall) begin
                cfg_pending <= load_ok;
                cfg_err     <= ~load_ok;
            end else if (scan_rise || commit) begin
                cfg_pending <= 1'b0;
            end

            // Commit samples the pre-shift shadow even if a new burst starts on this edge.
            if (commit) begin
                hdr_out   <= shadow[HDR_OFF +: HDR_BITS];
                cfg_valid <= 1'b1;
                for (int i = 0; i < MEM_LEN; i++) begin
                    act_mem[i] <= shadow[MEM_OFF + i*DATA_W +: DATA_W];
                end
            end

            d_out_0 <= rd0_ok ? act_mem[idx0] : '0;
            d_out_1 <= rd1_ok ? act_mem[idx1] : '0;
        end
    end

endmodule
